bp_me_dram_stream_mem: RTL
==========================

// Module: bp_me_dram_stream_mem
// PURPOSE
//  Downstream memory endpoint for the L2 cache slice DMA streams. Consumes a DRAM
//  command header plus a dword data stream, and services it from an internal word array.
//  Returns a DRAM response header, followed by read data beats for reads.
//  Used as the backing store in slice-level and tile-level simulation and FPGA bring-up.
// PARAMETERS
//  bp_params_p     e_bp_default_cfg   proc config; supplies paddr_width_p, dword_width_p, cce_block_width_p
//  mem_els_p       4096               number of dword_width_p words in the array (power of 2)
//  lat_p           4                  cycles between command acceptance/last write beat and response header
// PORTS
//  clk_i                    in   1                              clock
//  reset_i                  in   1                              synchronous, active-high reset
//  mem_cmd_header_i         in   dram_mem_msg_header_width_lp   bp_dram_mem_msg_header_s {msg_type,size,addr,payload}
//  mem_cmd_header_v_i       in   1                              header valid
//  mem_cmd_header_yumi_o    out  1                              header consumed this cycle
//  mem_cmd_data_i           in   dword_width_p                  write data beat
//  mem_cmd_data_v_i         in   1                              write data valid
//  mem_cmd_data_yumi_o      out  1                              write beat consumed this cycle
//  mem_resp_header_o        out  dram_mem_msg_header_width_lp   response header (echo of latched command header)
//  mem_resp_header_v_o      out  1                              response header valid
//  mem_resp_header_ready_i  in   1                              ready-and: transfer when v & ready
//  mem_resp_data_o          out  dword_width_p                  read data beat
//  mem_resp_data_v_o        out  1                              read data valid
//  mem_resp_data_ready_i    in   1                              ready-and: transfer when v & ready
// BEHAVIOUR
//  - Reset: state=READY; all v/yumi outputs 0; beat and latency counters 0; array contents not reset.
//    reset_i mid-transaction abandons it (no response). Writes already committed stay in the array.
//  - Beats: N = 2^(size-3) for size >= e_mem_msg_size_8, else N=1 (full dword written/read).
//    N is max cce_block_width_p/dword_width_p.
//  - Word index: base = addr[paddr_width_p-1:3] mod mem_els_p; beat k uses (base+k) mod mem_els_p (wraps).
//  - FSM, one transaction in flight:
//    READY:    header_yumi_o = header_v_i; on yumi latch header, beat=0, lat_cnt=0.
//              -> WR_DATA if msg_type==e_mem_msg_wr, else -> WAIT (or RESP_HDR if lat_p==0).
//    WR_DATA:  data_yumi_o = data_v_i; on yumi write array[base+beat] <= data_i, beat++.
//              Yumi on beat N-1 -> WAIT (RESP_HDR if lat_p==0). header_yumi_o held 0.
//    WAIT:     lat_cnt++ each cycle; at lat_cnt==lat_p-1 -> RESP_HDR.
//    RESP_HDR: header_v_o=1, header_o=latched header (payload echoed).
//              On ready: read -> RD_DATA with beat=0; write -> READY.
//    RD_DATA:  data_v_o=1, data_o=array[base+beat], held stable while !ready.
//              On ready beat++; transfer of beat N-1 -> READY.
//  - Latency: write response header rises lat_p+1 cycles after last-beat yumi.
//    Read response header rises lat_p+1 cycles after header yumi. lat_p==0 gives 1 cycle.
//  - header_v_o and data_v_o are never high together. Data beats arrive only after the header transfers.
//  - No new header is accepted in the cycle a transaction completes. READY is entered the next cycle.
//  - Data beats presented while in READY/WAIT/RESP_HDR/RD_DATA are not consumed (yumi=0).
//  - Unsupported msg_type (not wr/rd): treated as read of N beats (uncached ops are not issued by the slice).
// TESTING
//  1 Write 8 beats, size=e_mem_msg_size_64, addr=0x8000_0040, data 0..7, lat_p=4
//    -> 8 data yumis. resp hdr v 5 cycles after last yumi, echoing wr/addr. No resp data.
//  2 Read same block -> resp hdr then 8 beats 0..7 in order, header_v and data_v never coincident.
//  3 Read with mem_resp_data_ready_i toggling 1-0-1 every cycle -> data_o stable while stalled.
//    Still exactly 8 beats, correct order.
//  4 Write 8 beats at word index mem_els_p-4 (wrap), then read back
//    -> words land at indices mem_els_p-4..mem_els_p-1, 0..3. Readback matches.
//  5 size=e_mem_msg_size_8 write 0xDEAD_BEEF then read -> 1 beat each, readback 0xDEAD_BEEF.
//    size=e_mem_msg_size_4 read -> 1 beat.
//  6 Assert reset_i after 3 of 8 write beats, then issue new read of a different block
//    -> no response for aborted write. New read served normally. First 3 words hold new data.

Source files
------------

// File: rtl/bp_me_dram_stream_mem.sv
// DRAM-side memory endpoint: accepts a command header plus write beats and answers with an
// echoed response header, followed for reads by a stream of dword beats from a local array.
module bp_me_dram_stream_mem #(
    parameter int paddr_width_p       = 40,
    parameter int dword_width_p       = 64,
    parameter int cce_block_width_p   = 512,
    parameter int mem_payload_width_p = 16,
    parameter int mem_els_p           = 4096,
    parameter int lat_p               = 4,
    localparam int dram_mem_msg_header_width_lp = 4 + 3 + paddr_width_p + mem_payload_width_p
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [dram_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
    input  logic                                    mem_cmd_header_v_i,
    output logic                                    mem_cmd_header_yumi_o,
    input  logic [dword_width_p-1:0]                mem_cmd_data_i,
    input  logic                                    mem_cmd_data_v_i,
    output logic                                    mem_cmd_data_yumi_o,
    output logic [dram_mem_msg_header_width_lp-1:0] mem_resp_header_o,
    output logic                                    mem_resp_header_v_o,
    input  logic                                    mem_resp_header_ready_i,
    output logic [dword_width_p-1:0]                mem_resp_data_o,
    output logic                                    mem_resp_data_v_o,
    input  logic                                    mem_resp_data_ready_i
);
    localparam int hdr_w_lp        = dram_mem_msg_header_width_lp;
    localparam int max_beats_lp    = cce_block_width_p / dword_width_p;
    localparam int lg_max_beats_lp = $clog2(max_beats_lp);
    localparam int beat_w_lp       = $clog2(max_beats_lp + 1);
    localparam int idx_w_lp        = $clog2(mem_els_p);
    localparam int lat_w_lp        = (lat_p > 1) ? $clog2(lat_p) : 1;

    localparam logic [3:0] e_mem_msg_wr = 4'd1;

    localparam logic [2:0] s_ready    = 3'd0;
    localparam logic [2:0] s_wr_data  = 3'd1;
    localparam logic [2:0] s_wait     = 3'd2;
    localparam logic [2:0] s_resp_hdr = 3'd3;
    localparam logic [2:0] s_rd_data  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [hdr_w_lp-1:0]      hdr_q, hdr_d;
    logic [beat_w_lp-1:0]     beat_q, beat_d;
    logic [lat_w_lp-1:0]      lat_q, lat_d;
    logic [dword_width_p-1:0] mem_q [mem_els_p];

    logic [3:0]               cmd_type_li, msg_type_li;
    logic [2:0]               size_li;
    logic [paddr_width_p-1:0] addr_li;
    logic [idx_w_lp-1:0]      base_li, idx_li;
    logic [beat_w_lp-1:0]     last_beat_li;
    logic                     is_wr_li, lat_done_li;
    logic                     unused_addr_bits;

    assign cmd_type_li = mem_cmd_header_i[hdr_w_lp-1 -: 4];
    assign msg_type_li = hdr_q[hdr_w_lp-1 -: 4];
    assign size_li     = hdr_q[hdr_w_lp-5 -: 3];
    assign addr_li     = hdr_q[mem_payload_width_p +: paddr_width_p];
    assign base_li     = addr_li[3 +: idx_w_lp];
    assign idx_li      = base_li + idx_w_lp'(beat_q);
    assign is_wr_li    = (msg_type_li == e_mem_msg_wr);
    assign lat_done_li = (lat_q == lat_w_lp'(lat_p - 1));

    assign unused_addr_bits = ^{addr_li[2:0], addr_li[paddr_width_p-1:idx_w_lp+3]};

    // Sub-dword sizes still move one full dword; oversize requests clamp to a cache block.
    always_comb begin
        last_beat_li = '0;
        if (size_li > 3'd3) begin
            if (int'(size_li) - 3 >= lg_max_beats_lp)
                last_beat_li = beat_w_lp'(max_beats_lp - 1);
            else
                last_beat_li = beat_w_lp'((1 << (int'(size_li) - 3)) - 1);
        end
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        case (state_q)
            s_ready: begin
                if (mem_cmd_header_v_i) begin
                    hdr_d  = mem_cmd_header_i;
                    beat_d = '0;
                    lat_d  = '0;
                    if (cmd_type_li == e_mem_msg_wr)
                        state_d = s_wr_data;
                    else
                        state_d = (lat_p == 0) ? s_resp_hdr : s_wait;
                end
            end
            s_wr_data: begin
                if (mem_cmd_data_v_i) begin
                    beat_d = beat_q + beat_w_lp'(1);
                    if (beat_q == last_beat_li)
                        state_d = (lat_p == 0) ? s_resp_hdr : s_wait;
                end
            end
            s_wait: begin
                lat_d = lat_q + lat_w_lp'(1);
                if (lat_done_li)
                    state_d = s_resp_hdr;
            end
            s_resp_hdr: begin
                if (mem_resp_header_ready_i) begin
                    beat_d  = '0;
                    state_d = is_wr_li ? s_ready : s_rd_data;
                end
            end
            s_rd_data: begin
                if (mem_resp_data_ready_i) begin
                    beat_d = beat_q + beat_w_lp'(1);
                    if (beat_q == last_beat_li)
                        state_d = s_ready;
                end
            end
            default: state_d = s_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= s_ready;
            hdr_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    // Array contents deliberately survive reset so committed writes stay visible.
    always_ff @(posedge clk_i) begin
        if (mem_cmd_data_yumi_o)
            mem_q[idx_li] <= mem_cmd_data_i;
    end

    assign mem_cmd_header_yumi_o = (state_q == s_ready) & mem_cmd_header_v_i;
    assign mem_cmd_data_yumi_o   = (state_q == s_wr_data) & mem_cmd_data_v_i;
    assign mem_resp_header_o     = hdr_q;
    assign mem_resp_header_v_o   = (state_q == s_resp_hdr);
    assign mem_resp_data_o       = mem_q[idx_li];
    assign mem_resp_data_v_o     = (state_q == s_rd_data);

endmodule
